// File: rtl/ex_pkg.sv
// Shared definitions for the execute issue stage: opcode encodings, the
// S1 (issue) and S2 (writeback) entry layouts, and small operand helpers.
package ex_pkg;

    localparam int unsigned EX_XLEN   = 32;
    localparam int unsigned EX_REG_AW = 5;
    localparam int unsigned EX_IMM_W  = 16;
    localparam int unsigned SHAMT_W   = 5;

    localparam logic [2:0] OP_NOP0 = 3'b000;
    localparam logic [2:0] OP_NOP1 = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_SUBI = 3'b111;

    // Issue register contents: everything the ALU drive needs plus the
    // source indices used by the forwarding compare.
    typedef struct packed {
        logic [2:0]           op;
        logic [EX_REG_AW-1:0] rs1;
        logic [EX_REG_AW-1:0] rs2;
        logic [EX_XLEN-1:0]   rs1_val;
        logic [EX_XLEN-1:0]   rs2_val;
        logic                 use_imm;
        logic [EX_IMM_W-1:0]  imm;
        logic [EX_REG_AW-1:0] rd;
        logic                 we;
    } s1_entry_t;

    // Writeback register contents presented to the register file.
    typedef struct packed {
        logic [EX_REG_AW-1:0] rd;
        logic                 we;
        logic [EX_XLEN-1:0]   data;
    } s2_entry_t;

    function automatic logic [EX_XLEN-1:0] sext_imm(input logic [EX_IMM_W-1:0] imm);
        return {{(EX_XLEN-EX_IMM_W){imm[EX_IMM_W-1]}}, imm};
    endfunction

    function automatic logic is_nop(input logic [2:0] op);
        return (op == OP_NOP0) || (op == OP_NOP1);
    endfunction

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/ex_issue_stage_fwd.sv
// ex_fwd_unit: one-level result forwarding from the writeback register into
// the S1 register operands. Only built when EX_ISSUE_FWD_EN is defined; the
// default build has no compare logic at all.
`ifdef EX_ISSUE_FWD_EN
module ex_fwd_unit
    import ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              s2_valid_i,
    input  logic              s2_we_i,
    input  logic [REG_AW-1:0] s2_rd_i,
    input  logic [XLEN-1:0]   s2_data_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [XLEN-1:0]   rs1_val_i,
    input  logic [XLEN-1:0]   rs2_val_i,
    output logic [XLEN-1:0]   opa_o,
    output logic [XLEN-1:0]   opb_o
);

    logic fwd_a_s;
    logic fwd_b_s;

    // S2 is a valid source even while stalled, since S1 cannot advance past it.
    assign fwd_a_s = s2_valid_i && s2_we_i && (s2_rd_i == rs1_i);
    assign fwd_b_s = s2_valid_i && s2_we_i && (s2_rd_i == rs2_i);

    // Select register-file data or the pending writeback value per operand.
    always_comb begin
        opa_o = rs1_val_i;
        opb_o = rs2_val_i;
        if (fwd_a_s) begin
            opa_o = s2_data_i;
        end else begin
            opa_o = rs1_val_i;
        end
        if (fwd_b_s) begin
            opb_o = s2_data_i;
        end else begin
            opb_o = rs2_val_i;
        end
    end

endmodule
`endif

// File: rtl/ex_issue_stage.sv
// ex_issue_stage: two-entry execute wrapper around an external ALU.
// S1 latches decoded instructions and drives the ALU; S2 captures the ALU
// result for writeback. Define EX_ISSUE_FWD_EN to forward S2 into S1 operands.
module ex_issue_stage
    import ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic              in_use_imm,
    input  logic [15:0]       in_imm,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [2:0]        alu_op,
    input  logic [XLEN-1:0]   alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we,
    output logic [XLEN-1:0]   out_data
);

    s1_entry_t         s1_q, s1_d;
    logic              s1_valid_q, s1_valid_d;
    s2_entry_t         s2_q, s2_d;
    logic              s2_valid_q, s2_valid_d;

    logic              s2_free_s;
    logic              s1_adv_s;
    logic              accept_s;
    logic [XLEN-1:0]   opa_s;
    logic [XLEN-1:0]   opb_reg_s;
    logic [XLEN-1:0]   b_sel_s;

    assign s2_free_s = !s2_valid_q || out_ready;
    assign s1_adv_s  = s1_valid_q && s2_free_s;
    assign in_ready  = !s1_valid_q || s1_adv_s;
    assign accept_s  = in_valid && in_ready && !flush;

`ifdef EX_ISSUE_FWD_EN
    ex_fwd_unit #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_fwd (
        .s2_valid_i (s2_valid_q),
        .s2_we_i    (s2_q.we),
        .s2_rd_i    (s2_q.rd),
        .s2_data_i  (s2_q.data),
        .rs1_i      (s1_q.rs1),
        .rs2_i      (s1_q.rs2),
        .rs1_val_i  (s1_q.rs1_val),
        .rs2_val_i  (s1_q.rs2_val),
        .opa_o      (opa_s),
        .opb_o      (opb_reg_s)
    );
`else
    // Decode resolves hazards; source indices are carried but not compared.
    logic unused_rs_s;
    assign unused_rs_s = ^{s1_q.rs1, s1_q.rs2};
    assign opa_s       = s1_q.rs1_val;
    assign opb_reg_s   = s1_q.rs2_val;
`endif

    // Drive the ALU from S1; an empty S1 presents zero operands and opcode.
    always_comb begin
        b_sel_s = {XLEN{1'b0}};
        alu_op  = OP_NOP0;
        alu_a   = {XLEN{1'b0}};
        alu_b   = {XLEN{1'b0}};
        if (s1_valid_q) begin
            alu_op = s1_q.op;
            alu_a  = opa_s;
            if (s1_q.use_imm) begin
                b_sel_s = sext_imm(s1_q.imm);
            end else begin
                b_sel_s = opb_reg_s;
            end
            if (is_shift(s1_q.op)) begin
                alu_b = {{(XLEN-SHAMT_W){1'b0}}, b_sel_s[SHAMT_W-1:0]};
            end else begin
                alu_b = b_sel_s;
            end
        end else begin
            alu_op = OP_NOP0;
            alu_a  = {XLEN{1'b0}};
            alu_b  = {XLEN{1'b0}};
        end
    end

    // Next state of both entries: flush wins, then S1->S2 advance and S1 refill.
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_d       = s2_q;
        s2_valid_d = s2_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_adv_s) begin
                s2_d.rd    = s1_q.rd;
                s2_d.we    = s1_q.we && !is_nop(s1_q.op);
                s2_d.data  = alu_result;
                s2_valid_d = 1'b1;
            end else if (out_ready) begin
                s2_valid_d = 1'b0;
            end else begin
                s2_valid_d = s2_valid_q;
            end

            if (accept_s) begin
                s1_d.op      = in_op;
                s1_d.rs1     = in_rs1;
                s1_d.rs2     = in_rs2;
                s1_d.rs1_val = in_rs1_val;
                s1_d.rs2_val = in_rs2_val;
                s1_d.use_imm = in_use_imm;
                s1_d.imm     = in_imm;
                s1_d.rd      = in_rd;
                s1_d.we      = in_we && (in_rd != {REG_AW{1'b0}});
                s1_valid_d   = 1'b1;
            end else if (s1_adv_s) begin
                s1_valid_d = 1'b0;
            end else begin
                s1_valid_d = s1_valid_q;
            end
        end
    end

    // State registers; reset discards any in-flight instruction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_q       <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_q       <= s2_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_rd    = s2_q.rd;
    assign out_we    = s2_q.we;
    assign out_data  = s2_q.data;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Self-checking bench for ex_issue_stage. An ALU stand-in drives alu_result;
// an in-flight instruction queue predicts results, order and handshakes.
module tb_ex_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_val, in_rs2_val;
    logic        in_use_imm;
    logic [15:0] in_imm;
    logic        in_we;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        out_valid, out_ready, out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;
    int n_consumed = 0;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    ex_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_rd(in_rd), .in_we(in_we),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_we(out_we), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU stand-in: shifts use the full B value, so an unmasked
    // shift amount from the stage shows up as a wrong result.
    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b010, 3'b110: return a + b;
            3'b011, 3'b111: return a - b;
            3'b100:         return a << b;
            3'b101:         return a >> b;
            default:        return 32'h0;
        endcase
    endfunction
    assign alu_result = alu_ref(alu_op, alu_a, alu_b);

    // Architectural result of one instruction given its final operands.
    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b010, 3'b110: return a + b;
            3'b011, 3'b111: return a - b;
            3'b100:         return a << b[4:0];
            3'b101:         return a >> b[4:0];
            default:        return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model state: one queue of accepted, not-yet-consumed instructions.
    exp_t        m_prev, m_new;
    logic [31:0] m_a, m_b;
    logic        m_acc, m_con;

    // Compare outputs against the model each cycle, then apply this edge's events.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, !(q.size() == 2 && !out_ready)});
            if (q.size() == 0) chk("out_valid_idle", {31'b0, out_valid}, 32'd0);
            if (q.size() == 2) chk("out_valid_full", {31'b0, out_valid}, 32'd1);
            if (out_valid && q.size() > 0) begin
                chk("out_rd", {27'b0, out_rd}, {27'b0, q[0].rd});
                chk("out_we", {31'b0, out_we}, {31'b0, q[0].we});
                chk("out_data", out_data, q[0].data);
            end
            m_acc = in_valid && in_ready && !flush;
            m_con = out_valid && out_ready && !flush;
            if (flush) begin
                q.delete();
            end else begin
                if (m_con && q.size() > 0) begin
                    void'(q.pop_front());
                    n_consumed++;
                end
                if (m_acc) begin
                    m_a = in_rs1_val;
                    m_b = in_use_imm ? {{16{in_imm[15]}}, in_imm} : in_rs2_val;
`ifdef EX_ISSUE_FWD_EN
                    if (q.size() > 0) begin
                        m_prev = q[$];
                        if (m_prev.we && m_prev.rd == in_rs1) m_a = m_prev.data;
                        if (!in_use_imm && m_prev.we && m_prev.rd == in_rs2) m_b = m_prev.data;
                    end
`endif
                    m_new.rd   = in_rd;
                    m_new.we   = in_we && (in_rd != 5'd0) && (in_op != 3'b000) && (in_op != 3'b001);
                    m_new.data = model_result(in_op, m_a, m_b);
                    q.push_back(m_new);
                end
            end
        end
    end

    // Present one instruction and hold it until an accepting edge.
    task automatic send(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] v1, input logic [31:0] v2, input logic ui,
                        input logic [15:0] imm, input logic [4:0] rd, input logic we);
        logic rdy;
        int   n;
        in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rs1_val = v1; in_rs2_val = v2;
        in_use_imm = ui; in_imm = imm; in_rd = rd; in_we = we; in_valid = 1'b1;
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("send_accept", {31'b0, rdy}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int          base;
    logic [31:0] held;
    logic        rdy_c;
    int          nc;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rs1_val = 32'd0; in_rs2_val = 32'd0;
        in_use_imm = 1'b0; in_imm = 16'd0; in_rd = 5'd0; in_we = 1'b0;
        idle(2);
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_we", {31'b0, out_we}, 32'd0);
        chk("rst_out_rd", {27'b0, out_rd}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", {29'b0, alu_op}, 32'd0);
        @(posedge clk); #1;

        // ADD 5+7: out_valid two edges after accept
        out_ready = 1'b1;
        send(3'b010, 5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 16'd0, 5'd3, 1'b1);
        @(negedge clk);
        chk("add_lat1_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("add_lat2_valid", {31'b0, out_valid}, 32'd1);
        chk("add_data", out_data, 32'd12);
        idle(2);

        // SUBI 10 - sext(FFFF) = 11
        send(3'b111, 5'd1, 5'd2, 32'd10, 32'd0, 1'b1, 16'hFFFF, 5'd4, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("subi_data", out_data, 32'd11);
        idle(2);

        // SLL 1 << 33 masks to a shift of 1
        send(3'b100, 5'd1, 5'd2, 32'd1, 32'd33, 1'b0, 16'd0, 5'd5, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("sll_data", out_data, 32'd2);
        idle(2);

        // NOP op 001 never writes
        send(3'b001, 5'd1, 5'd2, 32'd9, 32'd9, 1'b0, 16'd0, 5'd5, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("nop_valid", {31'b0, out_valid}, 32'd1);
        chk("nop_we", {31'b0, out_we}, 32'd0);
        chk("nop_data", out_data, 32'd0);
        idle(2);

        // rd = x0: no write and no forwarding into a following x0 reader
        send(3'b010, 5'd20, 5'd21, 32'd4, 32'd4, 1'b0, 16'd0, 5'd0, 1'b1);
        send(3'b010, 5'd0, 5'd0, 32'd1, 32'd1, 1'b0, 16'd0, 5'd6, 1'b1);
        @(negedge clk);
        chk("x0_we", {31'b0, out_we}, 32'd0);
        chk("x0_data", out_data, 32'd8);
        @(negedge clk);
        chk("x0_nofwd_data", out_data, 32'd2);
        idle(2);

        // Back-to-back RAW: r1 = 2+3, then r2 = r1 + r1 with stale operands
        send(3'b010, 5'd7, 5'd8, 32'd2, 32'd3, 1'b0, 16'd0, 5'd1, 1'b1);
        send(3'b010, 5'd1, 5'd1, 32'd0, 32'd0, 1'b0, 16'd0, 5'd2, 1'b1);
        @(negedge clk);
        chk("raw_first", out_data, 32'd5);
        @(negedge clk);
`ifdef EX_ISSUE_FWD_EN
        chk("raw_second_fwd", out_data, 32'd10);
`else
        chk("raw_second_nofwd", out_data, 32'd0);
`endif
        idle(3);

        // Backpressure: three ADDs against a stalled writeback
        base = n_consumed;
        out_ready = 1'b0;
        send(3'b010, 5'd10, 5'd11, 32'd1, 32'd1, 1'b0, 16'd0, 5'd7, 1'b1);
        send(3'b010, 5'd12, 5'd13, 32'd2, 32'd2, 1'b0, 16'd0, 5'd8, 1'b1);
        in_op = 3'b010; in_rs1 = 5'd14; in_rs2 = 5'd15; in_rs1_val = 32'd3; in_rs2_val = 32'd3;
        in_use_imm = 1'b0; in_rd = 5'd9; in_we = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_data0", out_data, 32'd2);
        held = out_data;
        @(negedge clk);
        chk("bp_stable", out_data, held);
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        rdy_c = 1'b0;
        nc = 0;
        while (!rdy_c && nc < 50) begin
            @(negedge clk);
            rdy_c = in_ready;
            @(posedge clk);
            #1;
            nc++;
        end
        in_valid = 1'b0;
        chk("bp_third_accept", {31'b0, rdy_c}, 32'd1);
        idle(4);
        chk("bp_consumed", n_consumed - base, 32'd3);
        chk("bp_drained", q.size(), 32'd0);

        // Flush with both entries full
        out_ready = 1'b0;
        send(3'b010, 5'd10, 5'd11, 32'd6, 32'd6, 1'b0, 16'd0, 5'd7, 1'b1);
        send(3'b011, 5'd12, 5'd13, 32'd9, 32'd4, 1'b0, 16'd0, 5'd8, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_alu_op", {29'b0, alu_op}, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset between clock edges with both entries full
        send(3'b010, 5'd10, 5'd11, 32'd6, 32'd6, 1'b0, 16'd0, 5'd7, 1'b1);
        send(3'b010, 5'd12, 5'd13, 32'd7, 32'd7, 1'b0, 16'd0, 5'd8, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_we", {31'b0, out_we}, 32'd0);
        chk("arst_rd", {27'b0, out_rd}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'b010, 5'd10, 5'd11, 32'd20, 32'd22, 1'b0, 16'd0, 5'd3, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("post_rst_data", out_data, 32'd42);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
